// File: rtl/spi_pkg.sv
// Shared types for the SPI register-access controller: FSM states, the
// {CPOL,CPHA} mode struct with its four standard encodings, and an edge helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Even edge count = leading edge; CPHA=0 samples on leading, CPHA=1 on trailing.
  function automatic logic is_sample_edge(input logic cpha, input logic edge_lsb);
    return (cpha == edge_lsb);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator and SPI clock edge counter for spi_controller.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int EDGE_W  = 5
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic              en_i,
  input  logic              edge_en_i,
  output logic              tick_o,
  output logic [EDGE_W-1:0] edge_cnt_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              tick_s;

  // Divider restarts from zero whenever the controller is idle.
  always_comb begin
    tick_s = en_i && (div_q == DIV_MAX);
    div_d  = div_q;
    edge_d = edge_q;
    if (!en_i || tick_s) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (!edge_en_i) begin
      edge_d = {EDGE_W{1'b0}};
    end else if (tick_s) begin
      edge_d = edge_q + EDGE_W'(1);
    end else begin
      edge_d = edge_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      div_q  <= {DIV_W{1'b0}};
      edge_q <= {EDGE_W{1'b0}};
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
    end
  end

  assign tick_o     = tick_s;
  assign edge_cnt_o = edge_q;

endmodule

// File: rtl/spi_controller.sv
// SPI master issuing {wr_rdn, addr, data} register frames in any CPOL/CPHA mode.
// Define SPI_CTRL_LOOPBACK_EN to add a loopback input that samples spi_mosi instead of spi_miso.
module spi_controller
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
`ifdef SPI_CTRL_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [REG_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N      = 1 + ADDR_W + REG_W;
  localparam int EDGE_W = $clog2(2 * N + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * N - 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic              wr_q, wr_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [REG_W-1:0]  rx_q, rx_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  logic              tick_s;
  logic [EDGE_W-1:0] edge_cnt_s;
  logic              miso_s;
  logic              accept_s;
  logic [N-1:0]      frame_s;

  spi_clkgen #(
    .CLK_DIV (CLK_DIV),
    .EDGE_W  (EDGE_W)
  ) u_clkgen (
    .clk_i      (clk),
    .rstb_i     (rstb),
    .en_i       (state_q != ST_IDLE),
    .edge_en_i  (state_q == ST_SHIFT),
    .tick_o     (tick_s),
    .edge_cnt_o (edge_cnt_s)
  );

`ifdef SPI_CTRL_LOOPBACK_EN
  assign miso_s = loopback ? mosi_q : spi_miso;
`else
  assign miso_s = spi_miso;
`endif

  assign accept_s = start && ena && !busy_q;
  assign frame_s  = {wr_rdn, addr, (wr_rdn ? wdata : {REG_W{1'b0}})};

  // Next-state and output logic; mosi leads the first sample edge when CPHA=0.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wr_d    = wr_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d = mode[1];
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (accept_s) begin
          state_d = ST_SETUP;
          mode_d  = spi_mode_t'(mode);
          wr_d    = wr_rdn;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          if (mode[0]) begin
            tx_d   = frame_s;
            mosi_d = 1'b0;
          end else begin
            tx_d   = {frame_s[N-2:0], 1'b0};
            mosi_d = frame_s[N-1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          sclk_d = ~sclk_q;
          if (is_sample_edge(mode_q.cpha, edge_cnt_s[0])) begin
            rx_d = {rx_q[REG_W-2:0], miso_s};
          end else begin
            mosi_d = tx_q[N-1];
            tx_d   = {tx_q[N-2:0], 1'b0};
          end
          if (edge_cnt_s == LAST_EDGE) begin
            state_d = ST_HOLD;
            sclk_d  = mode_q.cpol;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sclk_d  = mode_q.cpol;
          if (!wr_q) begin
            rdata_d = rx_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame state and registered SPI/status outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE0;
      wr_q    <= 1'b0;
      tx_q    <= {N{1'b0}};
      rx_q    <= {REG_W{1'b0}};
      rdata_q <= {REG_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wr_q    <= wr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller (ADDR_W=4, REG_W=8, CLK_DIV=2, 13-bit frames).
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic [1:0] mode;
  logic       start;
  logic       wr_rdn;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
`ifdef SPI_CTRL_LOOPBACK_EN
  logic       loopback;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [12:0] miso_word;
  logic [12:0] mosi_cap = 13'h0000;
  int          mosi_n = 0;
  int          bit_idx = 0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;

  spi_controller #(
    .ADDR_W  (4),
    .REG_W   (8),
    .CLK_DIV (2)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .start    (start),
    .wr_rdn   (wr_rdn),
    .addr     (addr),
    .wdata    (wdata),
`ifdef SPI_CTRL_LOOPBACK_EN
    .loopback (loopback),
`endif
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Slave model: drives miso_word MSB first and captures mosi on the mode's sample edge.
  always @(spi_clk or spi_cs_n) begin
    if (cs_prev && !spi_cs_n) begin
      bit_idx  = 0;
      mosi_n   = 0;
      mosi_cap = 13'h0000;
      spi_miso = mode[0] ? 1'b0 : miso_word[12];
    end else if (!spi_cs_n && (spi_clk !== sclk_prev)) begin
      if (spi_clk !== mode[1]) begin
        if (mode[0]) begin
          spi_miso = miso_word[12 - bit_idx];
        end else begin
          mosi_cap = {mosi_cap[11:0], spi_mosi};
          mosi_n++;
        end
      end else begin
        if (mode[0]) begin
          mosi_cap = {mosi_cap[11:0], spi_mosi};
          mosi_n++;
        end
        bit_idx++;
        if (!mode[0] && bit_idx < 13) spi_miso = miso_word[12 - bit_idx];
      end
    end
    sclk_prev = spi_clk;
    cs_prev   = spi_cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame; extra_start / drop_ena give the in-frame cycle for a stray start / ena drop (-1 = none).
  task automatic run_frame(input string tag, input logic [1:0] md, input logic wr,
                           input logic [3:0] ad, input logic [7:0] wd, input logic [12:0] mw,
                           input logic [7:0] exp_rd, input int extra_start, input int drop_ena);
    int lat;
    int d0;
    logic [12:0] exp_mosi;
    exp_mosi = {wr, ad, (wr ? wd : 8'h00)};
    @(negedge clk);
    mode = md;
    ena = 1'b1;
    miso_word = mw;
    @(negedge clk);
    chk({tag, "/sclk_pre"}, 32'(spi_clk), 32'(md[1]));
    d0 = done_cnt;
    wr_rdn = wr;
    addr = ad;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_rdn = ~wr;
    addr = ~ad;
    wdata = ~wd;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      start = (lat == extra_start);
      if (lat == drop_ena) ena = 1'b0;
    end
    start = 1'b0;
    ena = 1'b1;
    chk({tag, "/latency"}, 32'(lat), 32'd56);
    chk({tag, "/mosi"}, 32'(mosi_cap), 32'(exp_mosi));
    chk({tag, "/mosi_bits"}, 32'(mosi_n), 32'd13);
    chk({tag, "/rdata"}, 32'(rdata), 32'(exp_rd));
    repeat (3) @(negedge clk);
    chk({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "/busy_after"}, 32'(busy), 32'd0);
    chk({tag, "/cs_after"}, 32'(spi_cs_n), 32'd1);
    chk({tag, "/mosi_idle"}, 32'(spi_mosi), 32'd0);
    chk({tag, "/sclk_post"}, 32'(spi_clk), 32'(md[1]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rstb = 1'b0;
    ena = 1'b0;
    mode = 2'b10;
    start = 1'b0;
    wr_rdn = 1'b0;
    addr = 4'h0;
    wdata = 8'h00;
    miso_word = 13'h0000;
`ifdef SPI_CTRL_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst/cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst/sclk", 32'(spi_clk), 32'd0);
    chk("rst/mosi", 32'(spi_mosi), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/rdata", 32'(rdata), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    chk("rst/sclk_cpol", 32'(spi_clk), 32'd1);

    run_frame("wr0", 2'b00, 1'b1, 4'h3, 8'hA5, 13'h0000, 8'h00, -1, -1);
    run_frame("rd3", 2'b11, 1'b0, 4'hC, 8'h33, {5'b10110, 8'h5A}, 8'h5A, -1, -1);
    run_frame("rd1", 2'b01, 1'b0, 4'h5, 8'h00, {5'b01001, 8'h81}, 8'h81, -1, -1);
    run_frame("rd0", 2'b00, 1'b0, 4'h9, 8'hFF, {5'b11111, 8'h3C}, 8'h3C, -1, -1);
    run_frame("rd2", 2'b10, 1'b0, 4'hF, 8'h00, {5'b00000, 8'h81}, 8'h81, -1, -1);
    run_frame("wr2_busy", 2'b10, 1'b1, 4'h6, 8'h5C, 13'h1FFF, 8'h81, 10, 12);

    // start with ena low must not open a frame
    d0 = done_cnt;
    @(negedge clk);
    ena = 1'b0;
    wr_rdn = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena0/busy", 32'(busy), 32'd0);
    chk("ena0/cs_n", 32'(spi_cs_n), 32'd1);
    chk("ena0/done", 32'(done_cnt - d0), 32'd0);

    // reset 20 cycles into a mode3 read
    @(negedge clk);
    mode = 2'b11;
    ena = 1'b1;
    miso_word = {5'b00000, 8'hEE};
    @(negedge clk);
    wr_rdn = 1'b0;
    addr = 4'h7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("abort/cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/sclk", 32'(spi_clk), 32'd0);
    chk("abort/rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("abort/sclk_cpol", 32'(spi_clk), 32'd1);
    repeat (60) @(negedge clk);
    chk("abort/no_done", 32'(done_cnt - d0), 32'd0);
    run_frame("rd_rec", 2'b00, 1'b0, 4'h2, 8'h00, {5'b00000, 8'hC3}, 8'hC3, -1, -1);

`ifdef SPI_CTRL_LOOPBACK_EN
    loopback = 1'b1;
    run_frame("lb_rd", 2'b00, 1'b0, 4'hA, 8'h00, 13'h1FFF, 8'h00, -1, -1);
    run_frame("lb_wr", 2'b01, 1'b1, 4'h4, 8'hA5, 13'h0000, 8'h00, -1, -1);
    chk("lb_wr/sampled", 32'(dut.rx_q), 32'h000000A5);
    loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
